// File: rtl/seq_multiplier.sv
// Radix-2 sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// Define SEQ_MULT_SIGNED_EN to add the tc port for two's-complement operands.
module seq_multiplier #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic                 tc,
`endif
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 tc_q, tc_d;
    logic                 tc_in;
    logic                 accept;
    logic                 last;

`ifdef SEQ_MULT_SIGNED_EN
    assign tc_in = tc;
`else
    assign tc_in = 1'b0;
`endif

    assign accept = (state_q != StRun) && start;
    assign last   = (state_q == StRun) && (cnt_q == CntW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy   = (state_q == StRun);
        done   = (state_q == StDone);
        result = result_q;
    end

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        tc_d     = tc_q;
        result_d = result_q;
        if (accept) begin
            mcand_d  = tc_in ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = '0;
            tc_d     = tc_in;
        end else if (state_q == StRun) begin
            // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so it subtracts.
            if (mplier_q[0]) begin
                acc_d = (last && tc_q) ? (acc_q - mcand_q) : (acc_q + mcand_q);
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (last) begin
                result_d = acc_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            tc_q     <= 1'b0;
            result_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed WIDTH=16 vectors plus free-running
// WIDTH=8 and WIDTH=32 instances, all checked each cycle against a cycle-count/product model.
module tb_seq_multiplier;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_d = 1'b0;
    logic [63:0] a_d = '0;
    logic [63:0] b_d = '0;
    logic        tc_d = 1'b0;
    logic        start_r = 1'b0;
    logic [63:0] a_r = '0;
    logic [63:0] b_r = '0;
    logic        tc_r = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Product of the low w bits of x and y, read as signed when s is set.
    function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y,
                                              input int w, input bit s);
        logic [127:0] mask, xe, ye;
        mask = ~128'd0 << w;
        xe   = {64'd0, x} & ~mask;
        ye   = {64'd0, y} & ~mask;
        if (s && x[w-1]) xe = xe | mask;
        if (s && y[w-1]) ye = ye | mask;
        return xe * ye;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);

        logic [2*W-1:0] result;
        logic           busy;
        logic           done;
        bit             tcm;
        logic           st;
        logic [W-1:0]   av, bv;

        assign st = (g == 0) ? start_d : start_r;
        assign av = (g == 0) ? a_d[W-1:0] : a_r[W-1:0];
        assign bv = (g == 0) ? b_d[W-1:0] : b_r[W-1:0];
`ifdef SEQ_MULT_SIGNED_EN
        assign tcm = (g == 0) ? tc_d : tc_r;
`else
        assign tcm = 1'b0;
`endif

        seq_multiplier #(.WIDTH(W)) u_dut (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (st),
            .a      (av),
            .b      (bv),
`ifdef SEQ_MULT_SIGNED_EN
            .tc     (tcm),
`endif
            .result (result),
            .busy   (busy),
            .done   (done)
        );

        // Model: an accepted operation is busy for W cycles, then done for one, result = product.
        int             cyc = 0;
        int             c0 = 0;
        bit             inflight = 1'b0;
        logic [2*W-1:0] pend = '0;
        logic [2*W-1:0] res_exp = '0;
        logic [127:0]   p;
        int             n_done = 0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inflight = 1'b0;
                res_exp  = '0;
            end else begin
                cyc++;
                if (st && (!inflight || (cyc - 1 - c0) >= W)) begin
                    p        = ref_prod({32'd0, 32'(av)}, {32'd0, 32'(bv)}, W, tcm);
                    pend     = p[2*W-1:0];
                    c0       = cyc;
                    inflight = 1'b1;
                end else if (inflight && (cyc - c0) == W) begin
                    res_exp = pend;
                end
            end
        end

        always @(negedge clk) begin : cmp
            int since;
            bit eb, ed;
            since = cyc - c0;
            eb    = rst_n && inflight && (since < W);
            ed    = rst_n && inflight && (since == W);
            check(busy === eb, $sformatf("w%0d busy cyc %0d", W, cyc), 128'(busy), 128'(eb));
            check(done === ed, $sformatf("w%0d done cyc %0d", W, cyc), 128'(done), 128'(ed));
            check(result === res_exp, $sformatf("w%0d result cyc %0d", W, cyc),
                  128'(result), 128'(res_exp));
            if (done === 1'b1) n_done++;
        end
    end

    // One directed multiply on the 16-bit instance, with literal latency and result checks.
    task automatic mul(input logic [15:0] x, input logic [15:0] y, input bit s,
                       input logic [31:0] exp, input string name);
        int k, nb;
        @(negedge clk);
        start_d = 1'b1; a_d = {48'd0, x}; b_d = {48'd0, y}; tc_d = s;
        @(negedge clk);
        start_d = 1'b0; a_d = 64'($urandom); b_d = 64'($urandom); tc_d = ~s;
        k  = 1;
        nb = 0;
        while (g_dut[0].done !== 1'b1 && k < 100) begin
            if (g_dut[0].busy === 1'b1) nb++;
            @(negedge clk);
            k++;
        end
        check(k - 1 == 16, {name, " latency"}, 128'(k - 1), 128'(16));
        check(nb == 16, {name, " busy cycles"}, 128'(nb), 128'(16));
        check(g_dut[0].result === exp, {name, " result"}, 128'(g_dut[0].result), 128'(exp));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            start_r = 1'b1;
            a_r     = {$urandom, $urandom};
            b_r     = {$urandom, $urandom};
            tc_r    = 1'($urandom);
        end
    end

    initial begin
        int nd, last;
        logic [31:0] r;
        repeat (2) @(negedge clk);
        check(g_dut[0].busy === 1'b0, "reset busy", 128'(g_dut[0].busy), 128'(0));
        check(g_dut[0].done === 1'b0, "reset done", 128'(g_dut[0].done), 128'(0));
        check(g_dut[0].result === 32'd0, "reset result", 128'(g_dut[0].result), 128'(0));
        rst_n = 1'b1;

        mul(16'h1101, 16'h1011, 1'b0, 32'h01113111, "basic");
        mul(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "max unsigned");
        mul(16'h0000, 16'hBEEF, 1'b0, 32'h00000000, "zero operand");
        mul(16'hFFFF, 16'h0002, 1'b0, 32'h0001FFFE, "ffff*2 unsigned");
        mul(16'h8000, 16'h8000, 1'b0, 32'h40000000, "8000^2 unsigned");
`ifdef SEQ_MULT_SIGNED_EN
        mul(16'hFFFF, 16'h0002, 1'b1, 32'hFFFFFFFE, "-1*2 signed");
        mul(16'h8000, 16'h8000, 1'b1, 32'h40000000, "min^2 signed");
`endif

        // A second start during RUN must be dropped.
        @(negedge clk);
        start_d = 1'b1; a_d = 64'd2; b_d = 64'd2; tc_d = 1'b0;
        @(negedge clk);
        start_d = 1'b0;
        repeat (4) @(negedge clk);
        start_d = 1'b1; a_d = 64'd3; b_d = 64'd3;
        @(negedge clk);
        start_d = 1'b0;
        nd = 0;
        r  = '0;
        repeat (40) begin
            @(negedge clk);
            if (g_dut[0].done === 1'b1) begin
                nd++;
                r = g_dut[0].result;
            end
        end
        check(nd == 1, "start during run done count", 128'(nd), 128'(1));
        check(r === 32'd4, "start during run result", 128'(r), 128'(4));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start_d = 1'b1; a_d = 64'h1234; b_d = 64'h5678;
        @(negedge clk);
        start_d = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check(g_dut[0].busy === 1'b0, "async reset busy", 128'(g_dut[0].busy), 128'(0));
        check(g_dut[0].done === 1'b0, "async reset done", 128'(g_dut[0].done), 128'(0));
        check(g_dut[0].result === 32'd0, "async reset result", 128'(g_dut[0].result), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (g_dut[0].done === 1'b1) nd++;
        end
        check(nd == 0, "no done after reset", 128'(nd), 128'(0));
        mul(16'h0007, 16'h0006, 1'b0, 32'h0000002A, "after reset");

        // start held high with changing operands: one result every WIDTH+1 cycles.
        @(negedge clk);
        start_d = 1'b1;
        last = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            a_d  = 64'($urandom);
            b_d  = 64'($urandom);
            tc_d = 1'($urandom);
            if (g_dut[0].done === 1'b1) begin
                if (last >= 0) check(i - last == 17, "held start period", 128'(i - last), 128'(17));
                last = i;
            end
        end
        start_d = 1'b0;
        repeat (20) @(negedge clk);

        check(g_dut[1].n_done > 10, "w8 result count", 128'(g_dut[1].n_done), 128'(11));
        check(g_dut[2].n_done > 5, "w32 result count", 128'(g_dut[2].n_done), 128'(6));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter: WIDTH, 16, operand width in bits; legal range 4..64.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a multiply, sampled on clk rising edge.
REQ-005 Port: a  input  WIDTH  multiplicand, sampled only on the accepting edge.
REQ-006 Port: b  input  WIDTH  multiplier, sampled only on the accepting edge.
REQ-007 Port: tc  input  1  two's-complement mode select (present only with SEQ_MULT_SIGNED_EN), sampled with a/b.
REQ-008 Port: result  output  2*WIDTH  product, registered.
REQ-009 Port: busy  output  1  high while a multiply is in progress.
REQ-010 Port: done  output  1  one-cycle pulse marking a new valid result.

Function
REQ-011 FSM states: IDLE, RUN, DONE; encoding is free.
REQ-012 IDLE or DONE with start=1 SHALL accept: latch a, b, tc; clear accumulator; bit counter=0; go to RUN.
REQ-013 IDLE with start=0 SHALL hold state; DONE with start=0 SHALL go to IDLE.
REQ-014 RUN: radix-2 shift-add, one multiplier bit per cycle, LSB first; exactly WIDTH RUN cycles, then DONE.
REQ-015 Latency: done SHALL be high in exactly the cycle after the WIDTH-th edge following the accepting edge; back-to-back throughput one result per WIDTH+1 cycles.
REQ-016 busy=1 exactly when state is RUN; done=1 exactly when state is DONE.
REQ-017 start while RUN SHALL be ignored; operands and progress unaffected; no queuing.
REQ-018 result SHALL update only on the edge entering DONE and hold its value until the next entry to DONE; intermediate accumulator values never appear on result.
REQ-019 Unsigned mode: result = a*b exactly, full 2*WIDTH bits, no truncation or overflow.
REQ-020 Operand of zero SHALL still take the full WIDTH RUN cycles (no early termination).
REQ-021 Changes on a/b/tc outside the accepting edge SHALL NOT affect the in-flight product.

Reset
REQ-022 rst_n low SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, result=0, counter=0, accumulator=0.
REQ-023 Reset asserted mid-RUN SHALL abandon the operation; no done pulse after release.
REQ-024 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Configuration
REQ-025 Macro SEQ_MULT_SIGNED_EN defined: port tc exists; tc=1 treats a, b as two's-complement and result is the signed 2*WIDTH product; tc=0 is unsigned; latency unchanged.
REQ-026 Macro SEQ_MULT_SIGNED_EN undefined: port tc absent; behaviour is unsigned only, identical to tc=0.
REQ-027 Signed case -2^(WIDTH-1) * -2^(WIDTH-1) SHALL yield +2^(2*WIDTH-2) without overflow.

Verification (WIDTH=16 unless stated)
REQ-028 start with a=0x1101, b=0x1011 -> done pulse exactly 16 edges after accept, result=0x01113111, busy high 16 cycles.
REQ-029 a=0xFFFF, b=0xFFFF unsigned -> result=0xFFFE0001; a=0x0000, b=0xBEEF -> result=0x00000000 after full 16 cycles.
REQ-030 SEQ_MULT_SIGNED_EN, tc=1: a=0xFFFF, b=0x0002 -> 0xFFFFFFFE; a=0x8000, b=0x8000 -> 0x40000000; same operands tc=0 -> 0x0001FFFE and 0x40000000.
REQ-031 start pulsed again with a=0x0003, b=0x0003 during RUN of 0x0002*0x0002 -> result=0x00000004, single done pulse, second request dropped.
REQ-032 rst_n asserted at RUN cycle 8 -> outputs zero immediately, no done; new start after release with a=0x0007, b=0x0006 -> result=0x0000002A.
REQ-033 start held high continuously with varying operands -> results every 17 cycles, each matching operands present on the DONE-cycle accepting edge; repeat with WIDTH=8 and WIDTH=32 random operands against a reference model.
